// File: rtl/ibus_imem_responder.sv
// Instruction-bus responder: word-addressed instruction memory answering fetches
// through an addr_ok/data_ok handshake after a programmable number of cycles.
module ibus_imem_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int                LATENCY   = 1,
    parameter logic [31:0]       OOR_WORD  = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ireq_valid,
    input  logic [ADDR_W-1:0]        ireq_addr,
    output logic                     iresp_addr_ok,
    output logic                     iresp_data_ok,
    output logic [31:0]              iresp_data,
    output logic                     iresp_err,
    input  logic [3:0]               extra_delay,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_idx,
    input  logic [31:0]              init_data,
    output logic                     busy
);

    localparam int                IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = BASE_ADDR + ADDR_W'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] latData_q;
    logic        latErr_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        dataOk_q;

    logic [31:0] mem [DEPTH];

    logic             reqErr;
    logic [IDX_W-1:0] reqIdx;
    logic [31:0]      reqData;
    logic [5:0]       nSum;
    logic [4:0]       nSat;

    // The index is only meaningful once the range check passes; otherwise the
    // read word is discarded in favour of OOR_WORD.
    assign reqErr  = (ireq_addr[1:0] != 2'b00) || (ireq_addr < BASE_ADDR) ||
                     (ireq_addr >= ADDR_LIMIT);
    assign reqIdx  = IDX_W'((ireq_addr - BASE_ADDR) >> 2);
    assign reqData = reqErr ? OOR_WORD : mem[reqIdx];
    assign nSum    = 6'(LATENCY) + 6'(extra_delay);
    assign nSat    = (nSum > 6'd31) ? 5'd31 : nSum[4:0];

    // Preload port; the accept path reads the pre-edge contents of the array.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            latData_q <= '0;
            latErr_q  <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            dataOk_q  <= 1'b0;
        end else begin
            dataOk_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ireq_valid) begin
                        latData_q <= reqData;
                        latErr_q  <= reqErr;
                        if (nSat > 5'd1) begin
                            state_q <= WAIT;
                            cnt_q   <= nSat - 5'd1;
                        end else begin
                            state_q  <= RESP;
                            data_q   <= reqData;
                            err_q    <= reqErr;
                            dataOk_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // cnt_q==1 means the next cycle is the N-th after accept.
                    if (cnt_q == 5'd1) begin
                        state_q  <= RESP;
                        cnt_q    <= '0;
                        data_q   <= latData_q;
                        err_q    <= latErr_q;
                        dataOk_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign iresp_addr_ok = (state_q == IDLE) && ireq_valid;
    assign iresp_data_ok = dataOk_q;
    assign iresp_data    = data_q;
    assign iresp_err     = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ibus_imem_responder.sv
// Scoreboard bench for ibus_imem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever data_ok is presented.
module tb_ibus_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ireq_valid = 1'b0;
    logic        valid15 = 1'b0;
    logic [63:0] ireq_addr = '0;
    logic [3:0]  extra_delay = '0;
    logic        init_we = 1'b0;
    logic [11:0] init_idx = '0;
    logic [31:0] init_data = '0;

    logic        addrOk, dataOk, err, busy;
    logic [31:0] data;
    logic        addrOk15, dataOk15, err15, busy15;
    logic [31:0] data15;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleCount = 0;

    ibus_imem_responder dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(addrOk), .iresp_data_ok(dataOk),
        .iresp_data(data), .iresp_err(err),
        .extra_delay(extra_delay),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
        .busy(busy)
    );

    // Second instance exists only to exercise the longest legal latency.
    ibus_imem_responder #(.LATENCY(15)) dut15 (
        .clk(clk), .rst(rst),
        .ireq_valid(valid15), .ireq_addr(ireq_addr),
        .iresp_addr_ok(addrOk15), .iresp_data_ok(dataOk15),
        .iresp_data(data15), .iresp_err(err15),
        .extra_delay(extra_delay),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
        .busy(busy15)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every data_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dataOk) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_data_ok", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("resp_data", {32'd0, data}, {32'd0, e.data});
                checkOutput("resp_err", {63'd0, err}, {63'd0, e.err});
                checkOutput("resp_cycle", 64'(cycleCount), 64'(e.cyc));
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] addr, input logic [3:0] extra,
                                 input logic [31:0] expData, input logic expErr,
                                 input int n, input bit push, output int waited);
        int budget;
        exp_t e;
        ireq_valid  = 1'b1;
        ireq_addr   = addr;
        extra_delay = extra;
        waited      = 0;
        budget      = 0;
        @(negedge clk);
        while (!addrOk && budget < 50) begin
            waited++;
            budget++;
            @(negedge clk);
        end
        if (!addrOk) begin
            checkOutput("addr_ok_timeout", 64'd0, 64'd1);
            ireq_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.data = expData;
            e.err  = expErr;
            e.cyc  = cycleCount + n - 1;
            sbQ.push_back(e);
        end
        ireq_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbQ.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbQ.size() > 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
    endtask

    task automatic initWord(input logic [11:0] idx, input logic [31:0] value);
        init_we   = 1'b1;
        init_idx  = idx;
        init_data = value;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int acc;
        int n;

        #1;
        checkOutput("rst_addr_ok", {63'd0, addrOk}, 64'd0);
        checkOutput("rst_data_ok", {63'd0, dataOk}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_data", {32'd0, data}, 64'd0);
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        initWord(12'd0, 32'h0000_0013);
        initWord(12'd1, 32'h0010_0093);
        initWord(12'd3, 32'h1111_1111);
        initWord(12'd4095, 32'hCAFE_F00D);

        // Basic back-to-back fetches at base latency.
        applyStimulus(64'h8000_0000, 4'd0, 32'h0000_0013, 1'b0, 1, 1'b1, w);
        checkOutput("addr_ok_first_cycle", 64'(w), 64'd0);
        applyStimulus(64'h8000_0004, 4'd0, 32'h0010_0093, 1'b0, 1, 1'b1, w);
        waitDrain(50);

        // Programmed stall: N = 6, busy for exactly six cycles.
        applyStimulus(64'h8000_0004, 4'd5, 32'h0010_0093, 1'b0, 6, 1'b1, w);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stall_busy_high", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        checkOutput("stall_busy_low", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        waitDrain(50);

        // Error cases plus the last in-range word.
        applyStimulus(64'h8000_0002, 4'd0, 32'h0, 1'b1, 1, 1'b1, w);
        applyStimulus(64'h7FFF_FFFC, 4'd0, 32'h0, 1'b1, 1, 1'b1, w);
        applyStimulus(64'h8000_4000, 4'd0, 32'h0, 1'b1, 1, 1'b1, w);
        applyStimulus(64'h8000_3FFC, 4'd0, 32'hCAFE_F00D, 1'b0, 1, 1'b1, w);
        waitDrain(50);

        // Init write and accept on the same edge return the old word.
        init_we   = 1'b1;
        init_idx  = 12'd3;
        init_data = 32'hDEAD_BEEF;
        applyStimulus(64'h8000_000C, 4'd0, 32'h1111_1111, 1'b0, 1, 1'b1, w);
        init_we = 1'b0;
        checkOutput("collision_same_edge", 64'(w), 64'd0);
        applyStimulus(64'h8000_000C, 4'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1, w);
        waitDrain(50);

        // Initiator changes address and wiggles valid while the responder waits.
        applyStimulus(64'h8000_0004, 4'd3, 32'h0010_0093, 1'b0, 4, 1'b1, w);
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_000C;
        @(posedge clk);
        #1;
        ireq_valid = 1'b0;
        ireq_addr  = 64'h8000_0000;
        waitDrain(50);

        // Async reset in the middle of a long wait aborts the transaction.
        applyStimulus(64'h8000_0004, 4'd8, 32'h0, 1'b0, 9, 1'b0, w);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("busy_before_rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_data_ok", {63'd0, dataOk}, 64'd0);
        checkOutput("midrst_err", {63'd0, err}, 64'd0);
        checkOutput("midrst_addr_ok", {63'd0, addrOk}, 64'd0);
        checkOutput("midrst_data", {32'd0, data}, 64'd0);
        #8 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        applyStimulus(64'h8000_0000, 4'd0, 32'h0000_0013, 1'b0, 1, 1'b1, w);
        waitDrain(50);

        // Longest latency: LATENCY=15 with extra_delay=15 gives N=30.
        ireq_addr   = 64'h8000_0000;
        extra_delay = 4'd15;
        valid15     = 1'b1;
        n = 0;
        @(negedge clk);
        while (!addrOk15 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checkOutput("sat_addr_ok", {63'd0, addrOk15}, 64'd1);
        @(posedge clk);
        #1;
        acc = cycleCount;
        valid15 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!dataOk15 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("sat_data_ok_seen", {63'd0, dataOk15}, 64'd1);
        checkOutput("sat_latency", 64'(cycleCount - acc + 1), 64'd30);
        checkOutput("sat_data", {32'd0, data15}, 64'h0000_0013);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
